shift_rot_seq: RTL and testbench
================================

Name: shift_rot_seq

Overview:
- Multi-cycle x86 group-2 unit (ROL/ROR/RCL/RCR/SHL/SHR/SAL/SAR) for 8/16/32-bit operands; the sequential successor of the core's combinational ALU.
- Shifts one bit position per clock under a start/busy/done handshake, so no wide barrel shifter is needed.
- Uses the same 12-bit flag word layout as the ALU: O=11, D=10, I=9, T=8, S=7, Z=6, A=4, P=2, C=0, bit1 reads as 1.
- Sits beside the ALU; the core sequencer stalls while busy is high.

Parameters:
- DATAW, 32, maximum operand width (8, 16 and 32 supported).
- CNTW, 5, count mask width; count is taken modulo 2^CNTW.
- FLAGW, 12, flag word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- isize  in  1  0 = byte, 1 = word or dword.
- opsize  in  1  with isize=1: 0 = 16-bit, 1 = 32-bit.
- mode  in  3  0 ROL, 1 ROR, 2 RCL, 3 RCR, 4 SHL, 5 SHR, 6 SAL (same as SHL), 7 SAR.
- op1  in  DATAW  operand.
- count  in  8  shift count; only the low CNTW bits are used.
- flags  in  FLAGW  incoming flags.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when result is valid.
- result  out  DATAW  result, zero-extended above the active width.
- flags_o  out  FLAGW  updated flags.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, busy=0, done=0, result=0, flags_o=12'h002.
- Active width W = 8 / 16 / 32 from isize/opsize, as in the ALU. N = count[CNTW-1:0].
- States: IDLE, RUN, DONE.
- IDLE:
  - On start, latch op1 (masked to W), flags, mode, W and N.
  - If N==0, go to DONE; otherwise go to RUN with cnt=N.
- RUN:
  - Each edge performs one 1-bit step on the working register and the working carry c, then decrements cnt.
  - When cnt goes 1→0, the state becomes DONE.
- Step definitions (c is the working carry; it is initialised to flags[0], and only RCL/RCR read it):
  - ROL: c=msb, r={r<<1, msb}.
  - ROR: c=lsb, r={lsb, r>>1}.
  - RCL: r={r<<1, c}, c=old msb.
  - RCR: r={c, r>>1}, c=old lsb.
  - SHL/SAL: c=msb, r=r<<1.
  - SHR: c=lsb, r=r>>1.
  - SAR: c=lsb, r=r>>1 with msb preserved.
- RCL/RCR therefore rotate through W+1 bits; an 8-bit RCR by 9 is the identity.
- DONE (exactly one cycle): done=1, then return to IDLE. result and flags_o are registered on entry to DONE and held until the next accepted start.
- Flags when N==0: result=op1 (masked to W), flags_o=flags unchanged.
- Flags for rotates (N>0):
  - Only C and O change. C=c.
  - ROL/RCL: O = msb(r) ^ c.
  - ROR/RCR: O = r[W-1] ^ r[W-2].
  - S, Z, A and P pass through from the input flags.
- Flags for shifts (N>0):
  - C=c.
  - SHL: O = msb(r) ^ c.
  - SHR: O = msb of the operand before the final step.
  - SAR: O = 0.
  - S = r[W-1]; Z = ~|r over W bits; P = ~^r[7:0]; A = 0.
- Pass-through bits: D, I, T, bit1 and the remaining bits always come from the latched flags.
- start is ignored in RUN and DONE; no queuing.
- Input changes after acceptance have no effect.
- Latency: done is high in the cycle after N+1 rising edges following the accepting edge. Maximum is 32 edges.
- Reset mid-RUN aborts the operation; no done pulse is produced.

Test Plan:
- SHL, 8-bit, op1=0x81, count=1 → done after 2 edges; result=0x02, C=1, O=1, S=0, Z=0, P=0, A=0.
- SAR, 16-bit, op1=0x8000, count=4 → done after 5 edges; result=0xF800, C=0, O=0, S=1, Z=0.
- RCR, 8-bit, op1=0x01, C=0, count=9 → result=0x01, C=0, O=0; S/Z/P equal to the input flags.
- ROL, 32-bit, op1=0x80000001, count=33 (masked to 1) → result=0x00000003, C=1, O=1. Then count=32 (masked to 0) → result=op1, flags_o=flags, done after 1 edge.
- Second start pulsed during RUN → ignored; exactly one done pulse and the first op's result.
- reset_n low mid-RUN → immediately busy=0, result=0, flags_o=0x002.
- After reset release, a new op completes normally.

Source files
------------

// File: rtl/shift_rot_seq.sv
// Sequential x86 group-2 shifter/rotator: one bit position per clock under a
// start/busy/done handshake, producing the ALU's 12-bit flag word on completion.
module shift_rot_seq #(
    parameter int DATAW = 32,
    parameter int CNTW  = 5,
    parameter int FLAGW = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             isize,
    input  logic             opsize,
    input  logic [2:0]       mode,
    input  logic [DATAW-1:0] op1,
    input  logic [7:0]       count,
    input  logic [FLAGW-1:0] flags,
    output logic             busy,
    output logic             done,
    output logic [DATAW-1:0] result,
    output logic [FLAGW-1:0] flags_o
);

    localparam int IW = $clog2(DATAW);
    localparam int FC = 0, FP = 2, FA = 4, FZ = 6, FS = 7, FO = 11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {
        M_ROL = 3'd0, M_ROR = 3'd1, M_RCL = 3'd2, M_RCR = 3'd3,
        M_SHL = 3'd4, M_SHR = 3'd5, M_SAL = 3'd6, M_SAR = 3'd7
    } mode_t;

    function automatic logic [DATAW-1:0] width_mask(input logic [IW-1:0] msb_idx);
        logic [63:0] ones;
        ones = (64'd2 << msb_idx) - 64'd1;
        return ones[DATAW-1:0];
    endfunction

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [IW-1:0]     msb_idx_q, msb_idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [DATAW-1:0]  r_q, r_d;
    logic              c_q, c_d;
    logic [FLAGW-1:0]  flags_in_q, flags_in_d;
    logic [DATAW-1:0]  result_q, result_d;
    logic [FLAGW-1:0]  flags_out_q, flags_out_d;

    logic [IW-1:0]     in_msb_idx;
    logic [CNTW-1:0]   in_cnt;
    logic [DATAW-1:0]  mask;
    logic              msb, lsb, left, ins, c_step;
    logic [DATAW-1:0]  r_step;
    logic [FLAGW-1:0]  fl_final;
    logic              unused_count;

    assign unused_count = ^count[7:CNTW];
    assign in_msb_idx   = !isize ? IW'(7) : (opsize ? IW'(31) : IW'(15));
    assign in_cnt       = count[CNTW-1:0];
    assign mask         = width_mask(msb_idx_q);
    assign msb          = r_q[msb_idx_q];
    assign lsb          = r_q[0];

    // One-bit datapath step; left-moving ops take the carry from the msb,
    // right-moving ops from the lsb, and only RCL/RCR feed the old carry back in.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        left = 1'b0;
        ins  = 1'b0;
        unique case (mode_q)
            M_ROL:         begin left = 1'b1; ins = msb; end
            M_RCL:         begin left = 1'b1; ins = c_q; end
            M_SHL, M_SAL:  begin left = 1'b1; ins = 1'b0; end
            M_ROR:         ins = lsb;
            M_RCR:         ins = c_q;
            M_SHR:         ins = 1'b0;
            M_SAR:         ins = msb;
        endcase
        c_step = left ? msb : lsb;
        r_step = left ? (((r_q << 1) | DATAW'(ins)) & mask)
                      : ((r_q >> 1) | (DATAW'(ins) << msb_idx_q));
    end

    always_comb begin
        fl_final     = flags_in_q;
        fl_final[FC] = c_step;
        unique case (mode_q)
            M_ROL, M_RCL: fl_final[FO] = r_step[msb_idx_q] ^ c_step;
            M_ROR, M_RCR: fl_final[FO] = r_step[msb_idx_q] ^ r_step[msb_idx_q - IW'(1)];
            default: begin
                if (mode_q == M_SHR)      fl_final[FO] = msb;
                else if (mode_q == M_SAR) fl_final[FO] = 1'b0;
                else                      fl_final[FO] = r_step[msb_idx_q] ^ c_step;
                fl_final[FS] = r_step[msb_idx_q];
                fl_final[FZ] = ~|r_step;
                fl_final[FA] = 1'b0;
                fl_final[FP] = ~^r_step[7:0];
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        msb_idx_d   = msb_idx_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        c_d         = c_q;
        flags_in_d  = flags_in_q;
        result_d    = result_q;
        flags_out_d = flags_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode_t'(mode);
                    msb_idx_d  = in_msb_idx;
                    cnt_d      = in_cnt;
                    r_d        = op1 & width_mask(in_msb_idx);
                    c_d        = flags[FC];
                    flags_in_d = flags;
                    if (in_cnt == '0) begin
                        state_d     = S_DONE;
                        result_d    = op1 & width_mask(in_msb_idx);
                        flags_out_d = flags;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r_d   = r_step;
                c_d   = c_step;
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d     = S_DONE;
                    result_d    = r_step;
                    flags_out_d = fl_final;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mode_q      <= M_ROL;
            msb_idx_q   <= IW'(7);
            cnt_q       <= '0;
            r_q         <= '0;
            c_q         <= 1'b0;
            flags_in_q  <= FLAGW'(2);
            result_q    <= '0;
            flags_out_q <= FLAGW'(2);
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            msb_idx_q   <= msb_idx_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            c_q         <= c_d;
            flags_in_q  <= flags_in_d;
            result_q    <= result_d;
            flags_out_q <= flags_out_d;
        end
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_DONE);
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign flags_o = flags_out_q;

endmodule

// File: tb/tb_shift_rot_seq.sv
// Directed self-checking bench for shift_rot_seq: hand-computed results, flags
// and completion latencies for each group-2 operation class.
module tb_shift_rot_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        isize = 1'b0;
    logic        opsize = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] op1 = '0;
    logic [7:0]  count = '0;
    logic [11:0] flags = 12'h002;
    logic        busy, done;
    logic [31:0] result;
    logic [11:0] flags_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    shift_rot_seq dut (
        .clock(clock), .reset_n(reset_n), .start(start), .isize(isize),
        .opsize(opsize), .mode(mode), .op1(op1), .count(count), .flags(flags),
        .busy(busy), .done(done), .result(result), .flags_o(flags_o)
    );

    always #5 clock = ~clock;

    // Launches one operation and counts rising edges (accepting edge included)
    // until done is seen; edges = -1 when the done pulse never arrives.
    task automatic run_op(input logic isz, input logic osz, input logic [2:0] md,
                          input logic [31:0] a, input logic [7:0] cv,
                          input logic [11:0] fin, output int edges,
                          output logic [31:0] res, output logic [11:0] fout);
        bit got;
        got = 1'b0;
        res = 'x;
        fout = 'x;
        @(negedge clock);
        isize = isz; opsize = osz; mode = md; op1 = a; count = cv; flags = fin;
        start = 1'b1;
        @(posedge clock);
        edges = 1;
        #1 start = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clock);
            if (done) begin
                got = 1'b1;
                res = result;
                fout = flags_o;
            end else begin
                @(posedge clock);
                edges++;
            end
        end
        if (!got) edges = -1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        total_cnt += 4;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
        if (flags_o !== 12'h002) $display("FAIL reset_flags got %h want 002", flags_o); else pass_cnt++;
    endtask

    task automatic test_shl8();
        int e; logic [31:0] r; logic [11:0] f;
        run_op(1'b0, 1'b0, 3'd4, 32'h0000_0081, 8'd1, 12'h702, e, r, f);
        total_cnt += 3;
        if (e !== 2) $display("FAIL shl8_edges got %0d want 2", e); else pass_cnt++;
        if (r !== 32'h02) $display("FAIL shl8_result got %h want 00000002", r); else pass_cnt++;
        if (f !== 12'hF03) $display("FAIL shl8_flags got %h want f03", f); else pass_cnt++;
        @(negedge clock);
        total_cnt += 2;
        if (done !== 1'b0) $display("FAIL shl8_done_width got %b want 0", done); else pass_cnt++;
        if (result !== 32'h02) $display("FAIL shl8_result_held got %h want 00000002", result); else pass_cnt++;
    endtask

    task automatic test_sar16();
        int e; logic [31:0] r; logic [11:0] f;
        run_op(1'b1, 1'b0, 3'd7, 32'hABCD_8000, 8'd4, 12'h0D7, e, r, f);
        total_cnt += 3;
        if (e !== 5) $display("FAIL sar16_edges got %0d want 5", e); else pass_cnt++;
        if (r !== 32'h0000_F800) $display("FAIL sar16_result got %h want 0000f800", r); else pass_cnt++;
        if (f !== 12'h086) $display("FAIL sar16_flags got %h want 086", f); else pass_cnt++;
    endtask

    task automatic test_rcr9();
        int e; logic [31:0] r; logic [11:0] f;
        run_op(1'b0, 1'b0, 3'd3, 32'h0000_0001, 8'd9, 12'hCC6, e, r, f);
        total_cnt += 3;
        if (e !== 10) $display("FAIL rcr9_edges got %0d want 10", e); else pass_cnt++;
        if (r !== 32'h01) $display("FAIL rcr9_result got %h want 00000001", r); else pass_cnt++;
        if (f !== 12'h4C6) $display("FAIL rcr9_flags got %h want 4c6", f); else pass_cnt++;
    endtask

    task automatic test_rcl8();
        int e; logic [31:0] r; logic [11:0] f;
        run_op(1'b0, 1'b0, 3'd2, 32'h0000_0080, 8'd1, 12'h002, e, r, f);
        total_cnt += 2;
        if (r !== 32'h00) $display("FAIL rcl8_result got %h want 00000000", r); else pass_cnt++;
        if (f !== 12'h803) $display("FAIL rcl8_flags got %h want 803", f); else pass_cnt++;
    endtask

    task automatic test_rol32_mask();
        int e; logic [31:0] r; logic [11:0] f;
        run_op(1'b1, 1'b1, 3'd0, 32'h8000_0001, 8'd33, 12'h0C6, e, r, f);
        total_cnt += 3;
        if (e !== 2) $display("FAIL rol33_edges got %0d want 2", e); else pass_cnt++;
        if (r !== 32'h0000_0003) $display("FAIL rol33_result got %h want 00000003", r); else pass_cnt++;
        if (f !== 12'h8C7) $display("FAIL rol33_flags got %h want 8c7", f); else pass_cnt++;
        run_op(1'b1, 1'b1, 3'd0, 32'h8000_0001, 8'd32, 12'h0C6, e, r, f);
        total_cnt += 3;
        if (e !== 1) $display("FAIL rol32_zero_edges got %0d want 1", e); else pass_cnt++;
        if (r !== 32'h8000_0001) $display("FAIL rol32_zero_result got %h want 80000001", r); else pass_cnt++;
        if (f !== 12'h0C6) $display("FAIL rol32_zero_flags got %h want 0c6", f); else pass_cnt++;
    endtask

    task automatic test_max_count();
        int e; logic [31:0] r; logic [11:0] f;
        run_op(1'b1, 1'b1, 3'd4, 32'h0000_0001, 8'd31, 12'h002, e, r, f);
        total_cnt += 3;
        if (e !== 32) $display("FAIL shl31_edges got %0d want 32", e); else pass_cnt++;
        if (r !== 32'h8000_0000) $display("FAIL shl31_result got %h want 80000000", r); else pass_cnt++;
        if (f !== 12'h886) $display("FAIL shl31_flags got %h want 886", f); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        logic [31:0] r = 'x;
        logic [11:0] f = 'x;
        @(negedge clock);
        isize = 1'b0; opsize = 1'b0; mode = 3'd5; op1 = 32'h0000_00F0; count = 8'd3; flags = 12'h002;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) begin
                dones++;
                r = result;
                f = flags_o;
            end
            if (i == 1) begin
                mode = 3'd4; op1 = 32'h0000_00FF; count = 8'd1; flags = 12'h0FF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        total_cnt += 4;
        if (dones !== 1) $display("FAIL b2b_done_pulses got %0d want 1", dones); else pass_cnt++;
        if (r !== 32'h1E) $display("FAIL b2b_result got %h want 0000001e", r); else pass_cnt++;
        if (f !== 12'h006) $display("FAIL b2b_flags got %h want 006", f); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL b2b_idle_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clock);
        isize = 1'b1; opsize = 1'b1; mode = 3'd4; op1 = 32'h0000_0005; count = 8'd20; flags = 12'h0C7;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        total_cnt += 4;
        if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_cnt++;
        if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else pass_cnt++;
        if (result !== 32'h0) $display("FAIL midrst_result got %h want 0", result); else pass_cnt++;
        if (flags_o !== 12'h002) $display("FAIL midrst_flags got %h want 002", flags_o); else pass_cnt++;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_after_reset();
        int e; logic [31:0] r; logic [11:0] f;
        run_op(1'b0, 1'b0, 3'd1, 32'h0000_0001, 8'd1, 12'h002, e, r, f);
        total_cnt += 3;
        if (e !== 2) $display("FAIL ror8_edges got %0d want 2", e); else pass_cnt++;
        if (r !== 32'h80) $display("FAIL ror8_result got %h want 00000080", r); else pass_cnt++;
        if (f !== 12'h803) $display("FAIL ror8_flags got %h want 803", f); else pass_cnt++;
    endtask

    initial begin
        #12 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        test_reset();
        test_shl8();
        test_sar16();
        test_rcr9();
        test_rcl8();
        test_rol32_mask();
        test_max_count();
        test_back_to_back();
        test_reset_mid_run();
        test_after_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
